// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback stage and its register file.
package wb_regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = 32;
  // Index of the hardwired-zero register.
  localparam int REG_ZERO   = 0;
endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB writeback inputs plus the two ID-stage read ports and the
// forwarding/debug outputs, bundled as one bus.
interface wb_regfile_if
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              wb_reg_write;
  logic              wb_mem_to_reg;
  logic [DATA_W-1:0] wb_result;
  logic [DATA_W-1:0] wb_mem_data;
  logic [ADDR_W-1:0] wb_dest;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] wb_data;
  logic              wb_commit;
  logic [CNT_W-1:0]  commit_count;

  // Pipeline side: drives MEM/WB fields and read indices.
  modport master (
    output wb_reg_write, wb_mem_to_reg, wb_result, wb_mem_data, wb_dest,
    output rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wb_commit, commit_count
  );

  // Register file side.
  modport slave (
    input  wb_reg_write, wb_mem_to_reg, wb_result, wb_mem_data, wb_dest,
    input  rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_commit, commit_count
  );
endinterface

// File: rtl/wb_regfile_regfile_core.sv
// Raw register storage: asynchronous clear, one write port, two
// combinational read ports. No r0 handling here; the caller masks it.
module regfile_core
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);
  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];

  // Storage: whole array clears on reset, otherwise single-port write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];
endmodule

// File: rtl/wb_regfile.sv
// Writeback stage fused with the register file: selects the writeback
// value, commits it, bypasses it onto same-cycle reads and counts commits.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_regfile_if.slave bus
);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] wb_sel;
  logic              commit;
  logic [DATA_W-1:0] raw_a;
  logic [DATA_W-1:0] raw_b;
  logic [DATA_W-1:0] rs_d;
  logic [DATA_W-1:0] rt_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  assign wb_sel = bus.wb_mem_to_reg ? bus.wb_mem_data : bus.wb_result;
  // Writes to r0 are not real writes: they neither store nor count.
  assign commit = bus.wb_reg_write && (bus.wb_dest != ZERO_IDX);

  regfile_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (commit),
    .waddr_i   (bus.wb_dest),
    .wdata_i   (wb_sel),
    .raddr_a_i (bus.rs_addr),
    .raddr_b_i (bus.rt_addr),
    .rdata_a_o (raw_a),
    .rdata_b_o (raw_b)
  );

  // Read port A: same-cycle bypass first, then r0 forced to zero.
  always_comb begin
    rs_d = raw_a;
    if (commit && (bus.rs_addr == bus.wb_dest)) begin
      rs_d = wb_sel;
    end else if (bus.rs_addr == ZERO_IDX) begin
      rs_d = '0;
    end
  end

  // Read port B: identical rule to port A.
  always_comb begin
    rt_d = raw_b;
    if (commit && (bus.rt_addr == bus.wb_dest)) begin
      rt_d = wb_sel;
    end else if (bus.rt_addr == ZERO_IDX) begin
      rt_d = '0;
    end
  end

  // Retired-write counter next state; wraps freely.
  always_comb begin
    cnt_d = cnt_q;
    if (commit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Retired-write counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.rs_data      = rs_d;
  assign bus.rt_data      = rt_d;
  assign bus.wb_data      = wb_sel;
  assign bus.wb_commit    = commit;
  assign bus.commit_count = cnt_q;
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: the writeback stage fused with the 32x32 general-purpose register file.
- Selects the writeback value (ALU result or load data), commits it to the destination register on the clock edge, and serves the two ID-stage read ports with same-cycle write bypass.
- Exports the writeback value for EX-stage forwarding and keeps a retired-write counter for debug/perf.

Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register index width (2**ADDR_W registers)
- CNT_W, 32, width of retired-write counter

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- wb_reg_write  input  1  RegWrite from MEM/WB
- wb_mem_to_reg  input  1  MemtoReg from MEM/WB: 1 selects load data, 0 selects ALU result
- wb_result  input  DATA_W  ALU result from MEM/WB
- wb_mem_data  input  DATA_W  memory read data from MEM/WB
- wb_dest  input  ADDR_W  destination register index from MEM/WB
- rs_addr  input  ADDR_W  read port A index (ID stage)
- rt_addr  input  ADDR_W  read port B index (ID stage)
- rs_data  output  DATA_W  read port A data
- rt_data  output  DATA_W  read port B data
- wb_data  output  DATA_W  selected writeback value (forwarding source)
- wb_commit  output  1  high when a real register write occurs this cycle
- commit_count  output  CNT_W  number of committed writes since reset

Behaviour:
- Reset: clk and rst_n form one clock domain. While rst_n=0, all registers r0..r31 clear to 0 and commit_count clears to 0, asynchronously, independent of clk. Deassertion takes effect at the next rising edge.
- wb_data = wb_mem_to_reg ? wb_mem_data : wb_result. Purely combinational, valid even when wb_reg_write=0.
- wb_commit = wb_reg_write && (wb_dest != 0). Combinational.
- Write: on a rising edge with rst_n=1 and wb_commit=1, reg[wb_dest] <= wb_data. Single write port, latency 1 cycle.
- r0 is hardwired to zero:
  - Writes to index 0 are dropped.
  - Reads of index 0 return 0.
  - A write to r0 does not count.
- Read ports are combinational (0-cycle latency).
- Bypass: if wb_commit=1 and rs_addr==wb_dest, rs_data=wb_data. Otherwise rs_data=reg[rs_addr]. Same rule for rt.
  - This removes the WB/ID structural hazard without a half-cycle write.
- Both read ports may address the same register, including the one being written; both see the bypassed value.
- commit_count increments by 1 on each edge where wb_commit=1. It wraps modulo 2**CNT_W with no saturation and no flag.
- X on wb_dest or wb_reg_write while rst_n=1 is a bench error. The RTL may propagate X.
- Reset asserted mid-cycle overrides a same-edge write: the register ends at 0.

Decomposition:
- Shared package: DATA_W and ADDR_W defaults, and the constant REG_ZERO=0.
- One natural sub-module, regfile_core: storage array, async clear, write port, raw read ports.
- The top level adds the writeback mux, the r0 masking/bypass logic and the counter.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle after writing r5=0x1234 -> rs_addr=5 reads 0 immediately, and commit_count=0.
- Writeback select: wb_reg_write=1, wb_dest=3, wb_result=0xAAAA0000, wb_mem_data=0x5555FFFF, wb_mem_to_reg=0 -> next cycle r3=0xAAAA0000. Repeat with wb_mem_to_reg=1 -> r3=0x5555FFFF, and commit_count=2.
- Bypass: same cycle as write r7=0xDEADBEEF, set rs_addr=rt_addr=7 -> rs_data=rt_data=0xDEADBEEF before the edge. With wb_reg_write=0 -> old r7 value.
- r0 protection: wb_reg_write=1, wb_dest=0, wb_result=0xFFFFFFFF -> wb_commit=0, rs_addr=0 reads 0 before and after the edge, commit_count unchanged.
- Counter wrap: set CNT_W=4 and perform 17 writes to r1 -> commit_count=1.
- Full sweep: write r1..r31 with value 0x100+i, then read all pairs (i, 32-i) -> each port returns 0x100+index, and r0 reads 0.
